// File: rtl/adder_nibble_sched.sv
// Round-robin scheduler that serialises NREQ multi-nibble adds through one shared 4-bit adder slice.
// Optional signed-overflow output resp_ovf_o is enabled by defining ADDER_NIBBLE_SCHED_OVF_EN.
module adder_nibble_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned W      = 4 * NIBBLES,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    input  logic [NREQ-1:0]   req_cin_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [IDW-1:0]    resp_id_o,
    output logic [W-1:0]      resp_sum_o,
    output logic              resp_cout_o,
    output logic [3:0]        add_a_o,
    output logic [3:0]        add_b_o,
    output logic              add_cin_o,
    input  logic [3:0]        add_sum_i,
    input  logic              add_cout_i
`ifdef ADDER_NIBBLE_SCHED_OVF_EN
    ,
    output logic              resp_ovf_o
`endif
);

    localparam int unsigned NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [NW-1:0]  nib_q, nib_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           resp_valid_q, resp_valid_d;

    logic           any_c;
    logic [IDW-1:0] grant_c;
    int unsigned    best_c;
    int unsigned    dist_c;

    // Grant goes to the valid requester closest to rr_ptr going upward (mod NREQ).
    always_comb begin
        any_c   = 1'b0;
        grant_c = '0;
        best_c  = NREQ;
        dist_c  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            dist_c = (i + NREQ - 32'(rr_ptr_q)) % NREQ;
            if (req_valid_i[i] && (dist_c < best_c)) begin
                best_c  = dist_c;
                grant_c = IDW'(i);
                any_c   = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (rst_n && (state_q == IDLE) && any_c) begin
            req_ready_o[grant_c] = 1'b1;
        end
    end

    always_comb begin
        add_a_o   = 4'h0;
        add_b_o   = 4'h0;
        add_cin_o = 1'b0;
        if (state_q == RUN) begin
            add_a_o   = a_q[nib_q*4 +: 4];
            add_b_o   = b_q[nib_q*4 +: 4];
            add_cin_o = carry_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        nib_d        = nib_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    a_d      = req_a_i[grant_c*W +: W];
                    b_d      = req_b_i[grant_c*W +: W];
                    carry_d  = req_cin_i[grant_c];
                    id_d     = grant_c;
                    nib_d    = '0;
                    rr_ptr_d = IDW'((32'(grant_c) + 1) % NREQ);
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_d[nib_q*4 +: 4] = add_sum_i;
                carry_d             = add_cout_i;
                nib_d               = nib_q + NW'(1);
                if (nib_q == NW'(NIBBLES - 1)) begin
                    nib_d        = '0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                // Return to IDLE only; the next accept happens a cycle later.
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            nib_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            nib_q        <= nib_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = id_q;
    assign resp_sum_o   = sum_q;
    assign resp_cout_o  = carry_q;

`ifdef ADDER_NIBBLE_SCHED_OVF_EN
    // Carry into the MSB is recovered as sum^a^b at bit W-1.
    assign resp_ovf_o = resp_valid_q & (carry_q ^ sum_q[W-1] ^ a_q[W-1] ^ b_q[W-1]);
`endif

endmodule

// File: tb/tb_adder_nibble_sched.sv
// Scoreboard bench for adder_nibble_sched with a behavioural 4-bit adder on the shared slice.
module tb_adder_nibble_sched;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 16;
    localparam int unsigned IDW     = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_sum;
    logic              resp_cout;
    logic [3:0]        add_a;
    logic [3:0]        add_b;
    logic              add_cin;
    logic [3:0]        add_sum;
    logic              add_cout;
`ifdef ADDER_NIBBLE_SCHED_OVF_EN
    logic              resp_ovf;
`endif

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cout;
        logic           ovf;
        logic [W-1:0]   sum;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   rr_model = 0;

    adder_nibble_sched #(.NREQ(NREQ), .NIBBLES(NIBBLES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_cin_i    (req_cin),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_sum_o   (resp_sum),
        .resp_cout_o  (resp_cout),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_cin_o    (add_cin),
        .add_sum_i    (add_sum),
        .add_cout_i   (add_cout)
`ifdef ADDER_NIBBLE_SCHED_OVF_EN
        ,
        .resp_ovf_o   (resp_ovf)
`endif
    );

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input int idx);
        logic [W:0]   s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        a     = req_a[idx*W +: W];
        b     = req_b[idx*W +: W];
        s     = {1'b0, a} + {1'b0, b} + (W+1)'(req_cin[idx]);
        e.id  = IDW'(idx);
        e.cout = s[W];
        e.sum = s[W-1:0];
        e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic rand_ops(input int idx);
        req_a[idx*W +: W] = W'($urandom);
        req_b[idx*W +: W] = W'($urandom);
        req_cin[idx]      = 1'($urandom);
    endtask

    // Response side: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != '0) check_eq("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_resp", 32'(resp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("resp_id", 32'(resp_id), 32'(e.id));
                    check_eq("resp_sum", 32'(resp_sum), 32'(e.sum));
                    check_eq("resp_cout", 32'(resp_cout), 32'(e.cout));
`ifdef ADDER_NIBBLE_SCHED_OVF_EN
                    check_eq("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Called in the low clock phase; serves n grants with both requesters kept valid.
    task automatic run_stream(input int n);
        int got    = 0;
        int budget = 0;
        int idx;
        while (got < n && budget < 200) begin
            if (req_ready != '0) begin
                idx = req_ready[1] ? 1 : 0;
                check_eq("rr_grant", 32'(idx), 32'(rr_model));
                exp_q.push_back(mk_exp(idx));
                rr_model = (idx + 1) % NREQ;
                got++;
                @(posedge clk);
                #1;
                rand_ops(idx);
            end
            @(negedge clk);
            budget++;
        end
        check_eq("stream_grants", 32'(got), 32'(n));
    endtask

    task automatic do_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int         lat;
        int         budget;
        logic       c;
        logic [4:0] ns;
        @(posedge clk);
        #1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
        req_cin[idx]      = cin;
        req_valid[idx]    = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!req_ready[idx] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("accept", 32'(req_ready[idx]), 32'd1);
        if (!req_ready[idx]) begin
            req_valid[idx] = 1'b0;
            return;
        end
        exp_q.push_back(mk_exp(idx));
        rr_model = (idx + 1) % NREQ;
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        c   = cin;
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat <= 20) begin
            if (lat <= NIBBLES) begin
                check_eq("add_a", 32'(add_a), 32'(a[4*(lat-1) +: 4]));
                check_eq("add_b", 32'(add_b), 32'(b[4*(lat-1) +: 4]));
                check_eq("add_cin", 32'(add_cin), 32'(c));
                ns = 5'(a[4*(lat-1) +: 4]) + 5'(b[4*(lat-1) +: 4]) + 5'(c);
                c  = ns[4];
            end
            lat++;
            @(negedge clk);
        end
        check_eq("latency", 32'(lat), 32'(NIBBLES + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check_eq({tag, "_resp_sum"}, 32'(resp_sum), 32'd0);
        check_eq({tag, "_resp_cout"}, 32'(resp_cout), 32'd0);
        check_eq({tag, "_add_a"}, 32'(add_a), 32'd0);
        check_eq({tag, "_add_b"}, 32'(add_b), 32'd0);
        check_eq({tag, "_add_cin"}, 32'(add_cin), 32'd0);
`ifdef ADDER_NIBBLE_SCHED_OVF_EN
        check_eq({tag, "_resp_ovf"}, 32'(resp_ovf), 32'd0);
`endif
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = '0;
        req_cin    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2 rst_n = 1'b0;
        rand_ops(0);
        rand_ops(1);
        req_valid = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Both requesters valid straight out of reset: strict alternation from req0.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_stream(4);
        req_valid = '0;
        wait_drain();

        do_req(0, 16'h00FF, 16'h0001, 1'b0);
        wait_drain();
        do_req(1, 16'hFFFF, 16'h0001, 1'b0);
        wait_drain();
        do_req(1, 16'h7FFF, 16'h0001, 1'b0);
        wait_drain();
        do_req(0, 16'h0000, 16'h0000, 1'b1);
        wait_drain();
        for (int i = 0; i < 4; i++) begin
            do_req(i % 2, W'($urandom), W'($urandom), 1'($urandom));
            wait_drain();
        end

        // Backpressure in DONE with a new request already pending.
        resp_ready = 1'b0;
        do_req(0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        #1;
        req_a[0 +: W] = 16'h0F0F;
        req_b[0 +: W] = 16'h0101;
        req_cin[0]    = 1'b1;
        req_valid[0]  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("hold_resp_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_resp_sum", 32'(resp_sum), 32'h5555);
            check_eq("hold_resp_id", 32'(resp_id), 32'd0);
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("no_accept_on_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("accept_after_resp", 32'(req_ready), 32'b01);
        exp_q.push_back(mk_exp(0));
        rr_model = 1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_drain();

        // Asynchronous reset during nibble 2 discards the operation.
        @(posedge clk);
        #1;
        req_a[0 +: W] = 16'hABCD;
        req_b[0 +: W] = 16'h1234;
        req_cin[0]    = 1'b0;
        req_valid[0]  = 1'b1;
        @(negedge clk);
        check_eq("accept_pre_rst", 32'(req_ready), 32'b01);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_add_a", 32'(add_a), 32'hB);
        #2;
        rst_n = 1'b0;
        rand_ops(0);
        rand_ops(1);
        req_valid = 2'b11;
        #1;
        check_reset_outputs("mid_run_rst");
        rr_model = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_stream(2);
        req_valid = '0;
        wait_drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
